riscv_memq: RTL and testbench

RISCV_MEMQ -- requirements
Module: riscv_memq

---
 rtl/biu_constants_pkg.sv | 20 ++
 rtl/riscv_memq.sv | 111 +++++++++++
 tb/tb_riscv_memq.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/biu_constants_pkg.sv
// Bus interface unit types shared between the MMU, the memory queue and the BIU.
package biu_constants_pkg;

   typedef enum logic [2:0] {
      BYTE  = 3'd0,
      HWORD = 3'd1,
      WORD  = 3'd2,
      DWORD = 3'd3,
      QWORD = 3'd4
   } biu_size_t;

   // prot bits: [2] instruction/data, [1] privileged, [0] cacheable
   typedef logic [2:0] biu_prot_t;

   localparam biu_prot_t PROT_DATA       = 3'b000;
   localparam biu_prot_t PROT_INSTR      = 3'b100;
   localparam biu_prot_t PROT_PRIVILEGED = 3'b010;
   localparam biu_prot_t PROT_CACHEABLE  = 3'b001;

endpackage

// File: rtl/riscv_memq.sv
// In-order request queue between the MMU and the memory system.
// Define RV_MEMQ_BYPASS_EN to let a request on an empty queue reach req_o in the same cycle.
module riscv_memq
   import biu_constants_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int PLEN  = XLEN,
   parameter int DEPTH = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,

   input  logic            req_i,
   input  logic [PLEN-1:0] adr_i,
   input  biu_size_t       size_i,
   input  logic            lock_i,
   input  biu_prot_t       prot_i,
   input  logic            we_i,
   input  logic [XLEN-1:0] d_i,
   output logic            full_o,
   input  logic            flush_i,

   output logic            req_o,
   output logic [PLEN-1:0] adr_o,
   output biu_size_t       size_o,
   output logic            lock_o,
   output biu_prot_t       prot_o,
   output logic            we_o,
   output logic [XLEN-1:0] d_o,

   input  logic            ack_i,
   input  logic [XLEN-1:0] q_i,
   output logic            ack_o,
   output logic [XLEN-1:0] q_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [PLEN-1:0] adr;
      biu_size_t       size;
      logic            lock;
      biu_prot_t       prot;
      logic            we;
      logic [XLEN-1:0] d;
   } memq_entry_t;

   memq_entry_t mem [DEPTH];
   memq_entry_t in_e, out_e;

   logic [AW:0]   count;
   logic [AW-1:0] rp, wp;
   logic          empty, bypass, push, pop;

   assign in_e  = '{adr: adr_i, size: size_i, lock: lock_i, prot: prot_i, we: we_i, d: d_i};
   assign empty = (count == '0);

`ifdef RV_MEMQ_BYPASS_EN
   assign bypass = empty & req_i & ~flush_i;
   assign out_e  = bypass ? in_e : mem[rp];
`else
   assign bypass = 1'b0;
   assign out_e  = mem[rp];
`endif

   assign full_o = (count == CNT_FULL);
   assign req_o  = ~empty | bypass;
   assign adr_o  = out_e.adr;
   assign size_o = out_e.size;
   assign lock_o = out_e.lock;
   assign prot_o = out_e.prot;
   assign we_o   = out_e.we;
   assign d_o    = out_e.d;

   assign ack_o  = ack_i;
   assign q_o    = q_i;

   // A bypassed request that is acked in the same cycle never needs a slot.
   assign push = req_i & ~full_o & ~flush_i & ~(bypass & ack_i);
   assign pop  = ~empty & ack_i;

   always_ff @(posedge clk_i) begin
      if (push) mem[wp] <= in_e;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count <= '0;
         rp    <= '0;
         wp    <= '0;
      end else if (flush_i) begin
         // Only the issued head survives a flush, and only until it is acked.
         if (!empty) begin
            wp <= rp + 1'b1;
            if (ack_i) begin
               rp    <= rp + 1'b1;
               count <= '0;
            end else begin
               count <= (AW+1)'(1);
            end
         end
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

endmodule

// File: tb/tb_riscv_memq.sv
// Directed self-checking bench for riscv_memq (default DEPTH=4, XLEN=PLEN=32).
module tb_riscv_memq;
   import biu_constants_pkg::*;

   logic        clk, rst_n;
   logic        req_i, lock_i, we_i, flush_i, ack_i;
   logic [31:0] adr_i, d_i, q_i;
   biu_size_t   size_i;
   biu_prot_t   prot_i;
   logic        full_o, req_o, lock_o, we_o, ack_o;
   logic [31:0] adr_o, d_o, q_o;
   biu_size_t   size_o;
   biu_prot_t   prot_o;

   int checks = 0;
   int failures = 0;

   riscv_memq #(.XLEN(32), .PLEN(32), .DEPTH(4)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_i(req_i), .adr_i(adr_i), .size_i(size_i), .lock_i(lock_i),
      .prot_i(prot_i), .we_i(we_i), .d_i(d_i), .full_o(full_o), .flush_i(flush_i),
      .req_o(req_o), .adr_o(adr_o), .size_o(size_o), .lock_o(lock_o),
      .prot_o(prot_o), .we_o(we_o), .d_o(d_o),
      .ack_i(ack_i), .q_i(q_i), .ack_o(ack_o), .q_o(q_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after a rising edge; checks happen 2 units later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic r, input logic [31:0] a);
      req_i  = r;
      adr_i  = a;
      d_i    = a ^ 32'hA5A5_0000;
      size_i = WORD;
      we_i   = a[2];
      lock_i = 1'b0;
      prot_i = PROT_DATA;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush_i = 1'b0; ack_i = 1'b0; q_i = '0;
      drive_req(1'b0, 32'h0);
      #2;
      checks++;
      if (req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", req_o); end
      checks++;
      if (full_o !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full_o); end
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_stray_ack();
      ack_i = 1'b1;
      cyc();
      ack_i = 1'b0;
      drive_req(1'b1, 32'h0000_0040);
      cyc();
      drive_req(1'b0, 32'h0);
      #2;
      checks++;
      if (req_o !== 1'b1 || adr_o !== 32'h40) begin
         failures++; $display("FAIL stray_ack req=%b adr=%h exp req=1 adr=00000040", req_o, adr_o);
      end
      ack_i = 1'b1;
      cyc();
      ack_i = 1'b0;
      #2;
      checks++;
      if (req_o !== 1'b0) begin failures++; $display("FAIL stray_ack_drain req=%b exp=0", req_o); end
      cyc();
   endtask

   task automatic test_latency();
      drive_req(1'b1, 32'h0000_0200);
      ack_i = 1'b1;
      #2;
`ifdef RV_MEMQ_BYPASS_EN
      checks++;
      if (req_o !== 1'b1 || adr_o !== 32'h200) begin
         failures++; $display("FAIL bypass_same_cycle req=%b adr=%h exp req=1 adr=00000200", req_o, adr_o);
      end
      cyc();
      drive_req(1'b0, 32'h0);
      ack_i = 1'b0;
      #2;
      checks++;
      if (req_o !== 1'b0) begin failures++; $display("FAIL bypass_not_stored req=%b exp=0", req_o); end
`else
      checks++;
      if (req_o !== 1'b0) begin failures++; $display("FAIL latency_same_cycle req=%b exp=0", req_o); end
      cyc();
      drive_req(1'b0, 32'h0);
      #2;
      checks++;
      if (req_o !== 1'b1 || adr_o !== 32'h200) begin
         failures++; $display("FAIL latency_next_cycle req=%b adr=%h exp req=1 adr=00000200", req_o, adr_o);
      end
      cyc();
      ack_i = 1'b0;
`endif
      cyc();
   endtask

   task automatic test_fill_drain();
      logic [31:0] a;
      for (int i = 0; i < 4; i++) begin
         drive_req(1'b1, 32'h100 + 32'(4*i));
         #2;
         checks++;
         if (full_o !== 1'b0) begin failures++; $display("FAIL fill_full_%0d got=%b exp=0", i, full_o); end
         cyc();
      end
      drive_req(1'b1, 32'h0000_0110);
      #2;
      checks++;
      if (full_o !== 1'b1 || req_o !== 1'b1 || adr_o !== 32'h100) begin
         failures++; $display("FAIL fill_full full=%b req=%b adr=%h exp 1 1 00000100", full_o, req_o, adr_o);
      end
      cyc();
      drive_req(1'b0, 32'h0);
      #2;
      checks++;
      if (full_o !== 1'b1 || adr_o !== 32'h100) begin
         failures++; $display("FAIL fill_ignored full=%b adr=%h exp 1 00000100", full_o, adr_o);
      end
      ack_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = 32'h100 + 32'(4*i);
         q_i = 32'hC0DE_0000 + 32'(i);
         #2;
         checks++;
         if (req_o !== 1'b1 || adr_o !== a || d_o !== (a ^ 32'hA5A5_0000) || we_o !== a[2] || size_o !== WORD) begin
            failures++; $display("FAIL drain_%0d req=%b adr=%h d=%h we=%b exp adr=%h", i, req_o, adr_o, d_o, we_o, a);
         end
         checks++;
         if (ack_o !== 1'b1 || q_o !== 32'hC0DE_0000 + 32'(i)) begin
            failures++; $display("FAIL passthru_%0d ack=%b q=%h", i, ack_o, q_o);
         end
         cyc();
      end
      ack_i = 1'b0;
      #2;
      checks++;
      if (req_o !== 1'b0 || full_o !== 1'b0) begin
         failures++; $display("FAIL drain_empty req=%b full=%b exp 0 0", req_o, full_o);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      drive_req(1'b1, 32'h300); cyc();
      drive_req(1'b1, 32'h304); cyc();
      ack_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         drive_req(1'b1, 32'h308 + 32'(4*k));
         #2;
         checks++;
         if (req_o !== 1'b1 || full_o !== 1'b0 || adr_o !== 32'h300 + 32'(4*k)) begin
            failures++; $display("FAIL b2b_%0d req=%b full=%b adr=%h exp adr=%h", k, req_o, full_o, adr_o, 32'h300 + 32'(4*k));
         end
         cyc();
      end
      drive_req(1'b0, 32'h0);
      for (int k = 0; k < 2; k++) begin
         #2;
         checks++;
         if (req_o !== 1'b1 || adr_o !== 32'h318 + 32'(4*k)) begin
            failures++; $display("FAIL b2b_tail_%0d req=%b adr=%h exp %h", k, req_o, adr_o, 32'h318 + 32'(4*k));
         end
         cyc();
      end
      ack_i = 1'b0;
      #2;
      checks++;
      if (req_o !== 1'b0) begin failures++; $display("FAIL b2b_empty req=%b exp=0", req_o); end
      cyc();
   endtask

   task automatic test_flush();
      drive_req(1'b1, 32'h400); cyc();
      drive_req(1'b1, 32'h404); cyc();
      drive_req(1'b1, 32'h408); cyc();
      drive_req(1'b1, 32'h40C);
      flush_i = 1'b1;
      cyc();
      flush_i = 1'b0;
      drive_req(1'b0, 32'h0);
      #2;
      checks++;
      if (req_o !== 1'b1 || adr_o !== 32'h400 || full_o !== 1'b0) begin
         failures++; $display("FAIL flush_head req=%b adr=%h full=%b exp 1 00000400 0", req_o, adr_o, full_o);
      end
      ack_i = 1'b1;
      cyc();
      ack_i = 1'b0;
      #2;
      checks++;
      if (req_o !== 1'b0) begin failures++; $display("FAIL flush_drop req=%b exp=0", req_o); end
      cyc();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) begin
         drive_req(1'b1, 32'h500 + 32'(4*i));
         cyc();
      end
      drive_req(1'b0, 32'h0);
      #1;
      checks++;
      if (full_o !== 1'b1) begin failures++; $display("FAIL pre_reset_full got=%b exp=1", full_o); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (req_o !== 1'b0 || full_o !== 1'b0) begin
         failures++; $display("FAIL async_reset req=%b full=%b exp 0 0", req_o, full_o);
      end
      cyc();
      rst_n = 1'b1;
      cyc();
      #2;
      checks++;
      if (req_o !== 1'b0) begin failures++; $display("FAIL post_reset req=%b exp=0", req_o); end
   endtask

   initial begin
      test_reset();
      test_stray_ack();
      test_latency();
      test_fill_drain();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
